id_ex_stage_reg: RTL and testbench

//  ID/EX pipeline register with load-use and JALR-dependence stall control.

---
 rtl/id_ex_stage_reg_pkg.sv | 40 ++++
 rtl/id_ex_stage_reg_hazard_detect.sv | 38 +++
 rtl/id_ex_stage_reg.sv | 107 ++++++++++
 tb/tb_id_ex_stage_reg.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/id_ex_stage_reg_pkg.sv
// Shared constants for the ID/EX stage: bubble instruction, opcodes, control bus bit positions.
// Latency: n/a (constants and a pure decode helper).
// Backpressure: n/a.
package id_ex_stage_reg_pkg;

  localparam int          XLEN_DEF   = 64;
  localparam int          CTRL_W_DEF = 12;
  localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;  // addi x0,x0,0

  // Base opcodes (instr[6:0])
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_32  = 7'b0111011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [2:0] F3_JALR = 3'b000;

  // Control bus layout {reg_write,mem_read,mem_write,mem_to_reg,alu_src,branch,jump,alu_op[4:0]}
  localparam int CTRL_REG_WRITE  = 11;
  localparam int CTRL_MEM_READ   = 10;
  localparam int CTRL_MEM_WRITE  = 9;
  localparam int CTRL_MEM_TO_REG = 8;
  localparam int CTRL_ALU_SRC    = 7;
  localparam int CTRL_BRANCH     = 6;
  localparam int CTRL_JUMP       = 5;

  // Only register-register, store and branch formats actually read the rs2 field;
  // for I-type formats those bits are immediate and must not trigger a stall.
  function automatic logic uses_rs2(input logic [6:0] opcode);
    return (opcode == OPC_OP) || (opcode == OPC_OP_32) ||
           (opcode == OPC_STORE) || (opcode == OPC_BRANCH);
  endfunction

endpackage

// File: rtl/id_ex_stage_reg_hazard_detect.sv
// Hazard detection between the instruction in ID and the producer in ID/EX.
// Latency: purely combinational.
// Backpressure: none; the stall decision is consumed by the ID/EX FSM.
module id_ex_stage_reg_hazard_detect
  import id_ex_stage_reg_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [4:0] rs1,
  input  logic [4:0] rs2,
  input  logic [4:0] rd_ex,
  input  logic       reg_write_ex,
  input  logic       mem_read_ex,
  output logic       load_use,
  output logic       jalr_dep,
  output logic       hazard,
  output logic [1:0] bubble_cnt
);

  logic producer_live;
  logic is_jalr;

  // rd=x0 in ID/EX is never a real producer, so it can never stall ID
  assign producer_live = (rd_ex != 5'd0);
  assign is_jalr       = (opcode == OPC_JALR) && (funct3 == F3_JALR);

  // Classify the dependence and how many bubbles it needs
  always_comb begin
    load_use   = mem_read_ex && producer_live &&
                 ((rd_ex == rs1) || ((rd_ex == rs2) && uses_rs2(opcode)));
    jalr_dep   = is_jalr && reg_write_ex && producer_live && (rd_ex == rs1);
    bubble_cnt = 2'd0;
    if (jalr_dep && mem_read_ex)   bubble_cnt = 2'd2;  // jalr target needs load data out of MEM
    else if (load_use || jalr_dep) bubble_cnt = 2'd1;
    hazard     = load_use || jalr_dep;
  end

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use / JALR-dependence stall FSM.
// Latency: 1 cycle ID->EX; pc_write/if_id_write are combinational from FSM state and hazard.
// Backpressure: hazards hold PC and IF/ID and insert bubbles; flush overrides any stall.
module id_ex_stage_reg
  import id_ex_stage_reg_pkg::*;
#(
  parameter int          XLEN   = XLEN_DEF,
  parameter int          CTRL_W = CTRL_W_DEF,
  parameter logic [31:0] NOP    = NOP_INSTR
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       instr_IF_ID,
  input  logic [XLEN-1:0]   pc_IF_ID,
  input  logic [XLEN-1:0]   rs1_data,
  input  logic [XLEN-1:0]   rs2_data,
  input  logic [XLEN-1:0]   imm,
  input  logic [CTRL_W-1:0] ctrl_ID,
  input  logic              flush,
  output logic              pc_write,
  output logic              if_id_write,
  output logic [31:0]       instr_ID_EX,
  output logic [XLEN-1:0]   pc_ID_EX,
  output logic [4:0]        rs1_ID_EX,
  output logic [4:0]        rs2_ID_EX,
  output logic [4:0]        rd_ID_EX,
  output logic [XLEN-1:0]   rs1_val_ID_EX,
  output logic [XLEN-1:0]   rs2_val_ID_EX,
  output logic [XLEN-1:0]   imm_ID_EX,
  output logic [CTRL_W-1:0] ctrl_ID_EX,
  output logic              valid_ID_EX
);

  localparam logic ST_RUN   = 1'b0;
  localparam logic ST_STALL = 1'b1;

  logic       state;
  logic [1:0] cnt;
  logic       load_use, jalr_dep, hazard;
  logic [1:0] bubble_cnt;
  logic       stall;

  id_ex_stage_reg_hazard_detect u_hazard (
    .opcode       (instr_IF_ID[6:0]),
    .funct3       (instr_IF_ID[14:12]),
    .rs1          (instr_IF_ID[19:15]),
    .rs2          (instr_IF_ID[24:20]),
    .rd_ex        (rd_ID_EX),
    .reg_write_ex (ctrl_ID_EX[CTRL_REG_WRITE]),
    .mem_read_ex  (ctrl_ID_EX[CTRL_MEM_READ]),
    .load_use     (load_use),
    .jalr_dep     (jalr_dep),
    .hazard       (hazard),
    .bubble_cnt   (bubble_cnt)
  );

  // Hazards are only looked at in RUN; STALL just counts down, and a redirect always frees the front end
  always_comb begin
    stall       = (state == ST_STALL) || hazard;
    pc_write    = flush || !stall;
    if_id_write = flush || !stall;
  end

  // Pipeline register plus stall FSM; priority rst > flush > stall bubble > normal load
  always_ff @(posedge clk) begin
    if (rst || flush || stall) begin
      instr_ID_EX   <= NOP;
      pc_ID_EX      <= '0;
      rs1_ID_EX     <= '0;
      rs2_ID_EX     <= '0;
      rd_ID_EX      <= '0;
      rs1_val_ID_EX <= '0;
      rs2_val_ID_EX <= '0;
      imm_ID_EX     <= '0;
      ctrl_ID_EX    <= '0;
      valid_ID_EX   <= 1'b0;
    end else begin
      instr_ID_EX   <= instr_IF_ID;
      pc_ID_EX      <= pc_IF_ID;
      rs1_ID_EX     <= instr_IF_ID[19:15];
      rs2_ID_EX     <= instr_IF_ID[24:20];
      rd_ID_EX      <= instr_IF_ID[11:7];
      rs1_val_ID_EX <= rs1_data;
      rs2_val_ID_EX <= rs2_data;
      imm_ID_EX     <= imm;
      ctrl_ID_EX    <= ctrl_ID;
      valid_ID_EX   <= 1'b1;
    end

    if (rst || flush) begin
      state <= ST_RUN;
      cnt   <= 2'd0;
    end else if (state == ST_STALL) begin
      cnt <= cnt - 2'd1;
      if (cnt == 2'd1) state <= ST_RUN;
    end else if (hazard) begin
      // The RUN-cycle bubble is the first one; STALL covers whatever remains
      cnt   <= bubble_cnt - 2'd1;
      state <= (bubble_cnt > 2'd1) ? ST_STALL : ST_RUN;
    end
  end

  // Diagnostic decode of the hazard class, kept for waveform visibility
  logic unused_ok;
  assign unused_ok = load_use ^ jalr_dep;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
module tb_id_ex_stage_reg;

  localparam int XLEN = 64;
  localparam int CW   = 12;

  localparam logic [31:0] NOP_I   = 32'h0000_0013;
  localparam logic [31:0] LW_X5   = 32'h0000_A283;  // lw x5,0(x1)
  localparam logic [31:0] ADD_565 = 32'h0022_8333;  // add x6,x5,x2
  localparam logic [31:0] ADDI_X7 = 32'h0040_0393;  // addi x7,x0,4
  localparam logic [31:0] JALR_X7 = 32'h0003_8067;  // jalr x0,0(x7)
  localparam logic [31:0] LW_X7   = 32'h0000_A383;  // lw x7,0(x1)
  localparam logic [31:0] LW_X0   = 32'h0000_A003;  // lw x0,0(x1)
  localparam logic [31:0] ADD_602 = 32'h0020_0333;  // add x6,x0,x2
  localparam logic [31:0] ADDI_615 = 32'h0050_8313; // addi x6,x1,5 (imm bits alias rs2=5)

  localparam logic [CW-1:0] C_LOAD = 12'hD80;
  localparam logic [CW-1:0] C_ALU  = 12'h802;
  localparam logic [CW-1:0] C_IMM  = 12'h880;
  localparam logic [CW-1:0] C_JALR = 12'h8A0;

  logic              clk = 1'b0;
  logic              rst;
  logic [31:0]       instr_IF_ID;
  logic [XLEN-1:0]   pc_IF_ID, rs1_data, rs2_data, imm;
  logic [CW-1:0]     ctrl_ID;
  logic              flush;
  logic              pc_write, if_id_write;
  logic [31:0]       instr_ID_EX;
  logic [XLEN-1:0]   pc_ID_EX;
  logic [4:0]        rs1_ID_EX, rs2_ID_EX, rd_ID_EX;
  logic [XLEN-1:0]   rs1_val_ID_EX, rs2_val_ID_EX, imm_ID_EX;
  logic [CW-1:0]     ctrl_ID_EX;
  logic              valid_ID_EX;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  id_ex_stage_reg dut (
    .clk(clk), .rst(rst), .instr_IF_ID(instr_IF_ID), .pc_IF_ID(pc_IF_ID),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm), .ctrl_ID(ctrl_ID),
    .flush(flush), .pc_write(pc_write), .if_id_write(if_id_write),
    .instr_ID_EX(instr_ID_EX), .pc_ID_EX(pc_ID_EX), .rs1_ID_EX(rs1_ID_EX),
    .rs2_ID_EX(rs2_ID_EX), .rd_ID_EX(rd_ID_EX), .rs1_val_ID_EX(rs1_val_ID_EX),
    .rs2_val_ID_EX(rs2_val_ID_EX), .imm_ID_EX(imm_ID_EX), .ctrl_ID_EX(ctrl_ID_EX),
    .valid_ID_EX(valid_ID_EX)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic [31:0] i, input logic [CW-1:0] c, input logic [XLEN-1:0] pc,
                        input logic [XLEN-1:0] a, input logic [XLEN-1:0] b, input logic [XLEN-1:0] im);
    instr_IF_ID = i; ctrl_ID = c; pc_IF_ID = pc; rs1_data = a; rs2_data = b; imm = im;
    #1;
  endtask

  task automatic settle();
    flush = 1'b0;
    set_id(NOP_I, '0, '0, '0, '0, '0);
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0;
    set_id(LW_X5, C_LOAD, 64'h40, 64'h11, 64'h22, 64'h0);
    tick(); tick();
    tests++; if (instr_ID_EX !== NOP_I) begin failed++; $display("FAIL reset_instr got %h want %h", instr_ID_EX, NOP_I); end
    tests++; if (valid_ID_EX !== 1'b0) begin failed++; $display("FAIL reset_valid got %b want 0", valid_ID_EX); end
    tests++; if (ctrl_ID_EX !== 12'h0) begin failed++; $display("FAIL reset_ctrl got %h want 000", ctrl_ID_EX); end
    tests++; if ({rd_ID_EX, rs1_ID_EX, rs2_ID_EX} !== 15'h0) begin failed++; $display("FAIL reset_regs got %h want 0", {rd_ID_EX, rs1_ID_EX, rs2_ID_EX}); end
    tests++; if ((pc_ID_EX | rs1_val_ID_EX | rs2_val_ID_EX | imm_ID_EX) !== 64'h0) begin failed++; $display("FAIL reset_data got nonzero pc/data/imm"); end
    rst = 1'b0;
    set_id(NOP_I, '0, '0, '0, '0, '0);
    tests++; if ({pc_write, if_id_write} !== 2'b11) begin failed++; $display("FAIL reset_release_write got %b want 11", {pc_write, if_id_write}); end
    tick();
  endtask

  task automatic test_load_use();
    settle();
    set_id(LW_X5, C_LOAD, 64'h100, 64'h0, 64'h0, 64'h0);
    tick();
    tests++; if ({valid_ID_EX, rd_ID_EX} !== {1'b1, 5'd5}) begin failed++; $display("FAIL lu_load_in got %b/%0d want 1/5", valid_ID_EX, rd_ID_EX); end
    set_id(ADD_565, C_ALU, 64'h104, 64'h1111, 64'h2222, 64'h0);
    tests++; if ({pc_write, if_id_write} !== 2'b00) begin failed++; $display("FAIL lu_stall got %b want 00", {pc_write, if_id_write}); end
    tick();
    tests++; if ({valid_ID_EX, instr_ID_EX, ctrl_ID_EX} !== {1'b0, NOP_I, 12'h0}) begin failed++; $display("FAIL lu_bubble got v=%b i=%h c=%h", valid_ID_EX, instr_ID_EX, ctrl_ID_EX); end
    tests++; if (pc_write !== 1'b1) begin failed++; $display("FAIL lu_release got %b want 1", pc_write); end
    tick();
    tests++; if ({valid_ID_EX, instr_ID_EX, rs1_ID_EX, rs2_ID_EX, rd_ID_EX} !== {1'b1, ADD_565, 5'd5, 5'd2, 5'd6})
      begin failed++; $display("FAIL lu_add_in got v=%b i=%h rs1=%0d rs2=%0d rd=%0d", valid_ID_EX, instr_ID_EX, rs1_ID_EX, rs2_ID_EX, rd_ID_EX); end
    tests++; if ({pc_ID_EX, rs1_val_ID_EX, rs2_val_ID_EX} !== {64'h104, 64'h1111, 64'h2222}) begin failed++; $display("FAIL lu_add_data got pc=%h a=%h b=%h", pc_ID_EX, rs1_val_ID_EX, rs2_val_ID_EX); end
  endtask

  task automatic test_jalr_alu();
    settle();
    set_id(ADDI_X7, C_IMM, 64'h200, 64'h0, 64'h0, 64'h4);
    tick();
    set_id(JALR_X7, C_JALR, 64'h204, 64'h4, 64'h0, 64'h0);
    tests++; if (pc_write !== 1'b0) begin failed++; $display("FAIL ja_stall got %b want 0", pc_write); end
    tick();
    tests++; if ({valid_ID_EX, pc_write} !== 2'b01) begin failed++; $display("FAIL ja_one_bubble got v=%b pcw=%b want 0/1", valid_ID_EX, pc_write); end
    tick();
    tests++; if ({valid_ID_EX, instr_ID_EX, pc_ID_EX} !== {1'b1, JALR_X7, 64'h204}) begin failed++; $display("FAIL ja_jalr_in got v=%b i=%h pc=%h", valid_ID_EX, instr_ID_EX, pc_ID_EX); end
  endtask

  task automatic test_jalr_load();
    settle();
    set_id(LW_X7, C_LOAD, 64'h300, 64'h0, 64'h0, 64'h0);
    tick();
    set_id(JALR_X7, C_JALR, 64'h304, 64'h0, 64'h0, 64'h0);
    tests++; if (pc_write !== 1'b0) begin failed++; $display("FAIL jl_stall1 got %b want 0", pc_write); end
    tick();
    tests++; if ({valid_ID_EX, pc_write, if_id_write} !== 3'b000) begin failed++; $display("FAIL jl_stall2 got %b want 000", {valid_ID_EX, pc_write, if_id_write}); end
    tick();
    tests++; if ({valid_ID_EX, pc_write} !== 2'b01) begin failed++; $display("FAIL jl_release got v=%b pcw=%b want 0/1", valid_ID_EX, pc_write); end
    tick();
    tests++; if ({valid_ID_EX, instr_ID_EX} !== {1'b1, JALR_X7}) begin failed++; $display("FAIL jl_jalr_in got v=%b i=%h", valid_ID_EX, instr_ID_EX); end
  endtask

  task automatic test_x0_and_rs2_alias();
    settle();
    set_id(LW_X0, C_LOAD, 64'h400, 64'h0, 64'h0, 64'h0);
    tick();
    set_id(ADD_602, C_ALU, 64'h404, 64'h0, 64'h7, 64'h0);
    tests++; if (pc_write !== 1'b1) begin failed++; $display("FAIL x0_no_stall got %b want 1", pc_write); end
    tick();
    tests++; if ({valid_ID_EX, instr_ID_EX} !== {1'b1, ADD_602}) begin failed++; $display("FAIL x0_add_in got v=%b i=%h", valid_ID_EX, instr_ID_EX); end
    set_id(LW_X5, C_LOAD, 64'h408, 64'h0, 64'h0, 64'h0);
    tick();
    set_id(ADDI_615, C_IMM, 64'h40C, 64'h9, 64'h0, 64'h5);
    tests++; if (pc_write !== 1'b1) begin failed++; $display("FAIL imm_rs2_alias got %b want 1", pc_write); end
    tick();
    tests++; if ({valid_ID_EX, imm_ID_EX} !== {1'b1, 64'h5}) begin failed++; $display("FAIL imm_in got v=%b imm=%h", valid_ID_EX, imm_ID_EX); end
  endtask

  task automatic test_flush_mid_stall();
    settle();
    set_id(LW_X7, C_LOAD, 64'h500, 64'h0, 64'h0, 64'h0);
    tick();
    set_id(JALR_X7, C_JALR, 64'h504, 64'h0, 64'h0, 64'h0);
    tick();
    tests++; if (pc_write !== 1'b0) begin failed++; $display("FAIL fl_in_stall got %b want 0", pc_write); end
    flush = 1'b1; #1;
    tests++; if ({pc_write, if_id_write} !== 2'b11) begin failed++; $display("FAIL fl_redirect got %b want 11", {pc_write, if_id_write}); end
    tick();
    flush = 1'b0;
    tests++; if ({valid_ID_EX, instr_ID_EX} !== {1'b0, NOP_I}) begin failed++; $display("FAIL fl_bubble got v=%b i=%h", valid_ID_EX, instr_ID_EX); end
    set_id(ADDI_X7, C_IMM, 64'h800, 64'h0, 64'h0, 64'h4);
    tests++; if (pc_write !== 1'b1) begin failed++; $display("FAIL fl_run got %b want 1", pc_write); end
    tick();
    tests++; if ({valid_ID_EX, pc_ID_EX} !== {1'b1, 64'h800}) begin failed++; $display("FAIL fl_next_in got v=%b pc=%h", valid_ID_EX, pc_ID_EX); end
  endtask

  task automatic test_reset_mid_stall();
    settle();
    set_id(LW_X7, C_LOAD, 64'h600, 64'h0, 64'h0, 64'h0);
    tick();
    set_id(JALR_X7, C_JALR, 64'h604, 64'h0, 64'h0, 64'h0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tests++; if ({valid_ID_EX, instr_ID_EX, rd_ID_EX} !== {1'b0, NOP_I, 5'd0}) begin failed++; $display("FAIL rs_bubble got v=%b i=%h rd=%0d", valid_ID_EX, instr_ID_EX, rd_ID_EX); end
    set_id(ADD_602, C_ALU, 64'h700, 64'h0, 64'h0, 64'h0);
    tests++; if (pc_write !== 1'b1) begin failed++; $display("FAIL rs_no_residual got %b want 1", pc_write); end
    tick();
    tests++; if ({valid_ID_EX, pc_ID_EX} !== {1'b1, 64'h700}) begin failed++; $display("FAIL rs_next_in got v=%b pc=%h", valid_ID_EX, pc_ID_EX); end
  endtask

  task automatic test_back_to_back();
    settle();
    for (int k = 0; k < 4; k++) begin
      set_id(ADD_602, C_ALU, 64'h900 + 64'(4 * k), 64'(k * 3), 64'(k + 100), 64'h0);
      tests++; if (pc_write !== 1'b1) begin failed++; $display("FAIL b2b_write[%0d] got %b want 1", k, pc_write); end
      tick();
      tests++; if ({valid_ID_EX, pc_ID_EX, rs1_val_ID_EX, rs2_val_ID_EX} !== {1'b1, 64'h900 + 64'(4 * k), 64'(k * 3), 64'(k + 100)})
        begin failed++; $display("FAIL b2b_data[%0d] got v=%b pc=%h a=%h b=%h", k, valid_ID_EX, pc_ID_EX, rs1_val_ID_EX, rs2_val_ID_EX); end
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_jalr_alu();
    test_jalr_load();
    test_x0_and_rs2_alias();
    test_flush_mid_stall();
    test_reset_mid_stall();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
